// File: rtl/branch_unit.sv
// Branch/hazard sequencer: drives the fetch PC and the pipeline FREEZE/BUBBLE/FLUSH/TAKEN controls.
// Optional BRANCH_STATS_EN adds saturating TAKEN_CNT / STALL_CNT statistics outputs.
module branch_unit (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       HOLD,
  input  logic       branch_update,
  input  logic [6:0] T4,
  input  logic [7:0] TGT,
  input  logic       CY,
  input  logic       WZ,
  output logic [7:0] PC,
  output logic       FREEZE,
  output logic       BUBBLE,
  output logic       FLUSH,
  output logic       TAKEN
`ifdef BRANCH_STATS_EN
  ,
  output logic [7:0] TAKEN_CNT,
  output logic [7:0] STALL_CNT
`endif
);

  localparam logic [6:0] T4_BR_W = 7'b1000001;
  localparam logic [6:0] T4_BR_C = 7'b1010000;

  typedef enum logic [1:0] {RUN, STALL, REDIR} state_t;

  state_t     state, state_nxt;
  logic [7:0] pc_nxt;
  logic       freeze_nxt, bubble_nxt, flush_nxt, taken_nxt;
  logic       is_br_w, is_br_c, br_taken;

  // Branch decode is qualified by branch_update; any other T4 is ordinary flow.
  always_comb begin
    is_br_w  = branch_update && (T4 == T4_BR_W);
    is_br_c  = branch_update && (T4 == T4_BR_C);
    br_taken = (is_br_w && WZ) || (is_br_c && CY);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= RUN;
      PC     <= 8'h00;
      FREEZE <= 1'b0;
      BUBBLE <= 1'b0;
      FLUSH  <= 1'b0;
      TAKEN  <= 1'b0;
    end else begin
      state  <= state_nxt;
      PC     <= pc_nxt;
      FREEZE <= freeze_nxt;
      BUBBLE <= bubble_nxt;
      FLUSH  <= flush_nxt;
      TAKEN  <= taken_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN, STALL: begin
        if (br_taken)  state_nxt = REDIR;
        else if (HOLD) state_nxt = STALL;
        else           state_nxt = RUN;
      end
      REDIR:   state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // A taken branch outranks HOLD, so FLUSH and BUBBLE are mutually exclusive by construction.
  always_comb begin
    pc_nxt     = PC + 8'd1;
    freeze_nxt = 1'b0;
    bubble_nxt = 1'b0;
    flush_nxt  = 1'b0;
    taken_nxt  = 1'b0;
    case (state)
      RUN, STALL: begin
        if (br_taken) begin
          pc_nxt    = TGT;
          flush_nxt = 1'b1;
          taken_nxt = 1'b1;
        end else if (HOLD) begin
          pc_nxt     = PC;
          freeze_nxt = 1'b1;
          bubble_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

`ifdef BRANCH_STATS_EN
  // Counters advance with the registered pulse they count, so they track TAKEN/FREEZE exactly.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      TAKEN_CNT <= 8'h00;
      STALL_CNT <= 8'h00;
    end else begin
      if (taken_nxt && (TAKEN_CNT != 8'hFF))  TAKEN_CNT <= TAKEN_CNT + 8'd1;
      if (freeze_nxt && (STALL_CNT != 8'hFF)) STALL_CNT <= STALL_CNT + 8'd1;
    end
  end
`endif

endmodule

// File: doc/branch_unit.md
BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-002 CLK  input  1  system clock; all state updates on the rising edge.
REQ-003 RST_N  input  1  asynchronous reset, active low.
REQ-004 HOLD  input  1  pipeline hazard request from the hazard unit, which updates it on the falling edge of CLK.
REQ-005 branch_update  input  1  branch microinstruction is entering execute; updated on the falling edge of CLK.
REQ-006 T4  input  7  control word of stage 4; bit 6 = PC write.
REQ-007 TGT  input  8  branch target address carried by the stage-4 microinstruction.
REQ-008 CY  input  1  current carry flag.
REQ-009 WZ  input  1  high when the W register equals zero.
REQ-010 PC  output  8  fetch address.
REQ-011 FREEZE  output  1  hold stage 1 and stage 2 registers.
REQ-012 BUBBLE  output  1  load a NOP (T=0) into stage 3.
REQ-013 FLUSH  output  1  clear stages 1-3 to NOP.
REQ-014 TAKEN  output  1  one-cycle pulse when a branch redirects PC.

Function
REQ-015 The block SHALL decode branch types only when branch_update=1: T4=7'b1000001 is BR_W (taken when WZ=1), T4=7'b1010000 is BR_C (taken when CY=1), and any other T4 is not a branch.
REQ-016 The FSM SHALL have three states, RUN, STALL and REDIR, with RUN as the reset state.
REQ-017 In RUN with no event, the block SHALL set PC <= PC+1 modulo 256, so that 8'hFF wraps to 8'h00.
REQ-018 In RUN or STALL, when branch_update=1 and the branch is taken, the block SHALL set PC <= TGT, go to REDIR, and assert FLUSH=1 and TAKEN=1 for exactly the next cycle.
REQ-019 In RUN or STALL, a not-taken branch or a non-branch T4 SHALL leave the flow unchanged (PC increments, or holds if HOLD=1).
REQ-020 When HOLD=1 and no taken branch is present in RUN or STALL, the block SHALL hold PC, go to or stay in STALL, and assert FREEZE=1 and BUBBLE=1 for the next cycle.
REQ-021 In STALL with HOLD=0 and no taken branch, the block SHALL return to RUN with PC <= PC+1.
REQ-022 When a taken branch and HOLD=1 occur in the same cycle, the block SHALL let the branch win, ignore HOLD, and keep FREEZE=0 and BUBBLE=0.
REQ-023 REDIR SHALL last exactly one cycle, during which HOLD and branch_update are ignored and PC <= PC+1 (first fetch after the target).
REQ-024 From REDIR the block SHALL go to RUN unconditionally.
REQ-025 All outputs SHALL be registered and SHALL change only on the rising edge of CLK or on reset.
REQ-026 FLUSH and BUBBLE SHALL never both be 1 in the same cycle.

Reset
REQ-027 When RST_N=0, the block SHALL immediately force state to RUN, PC to 8'h00, and FREEZE, BUBBLE, FLUSH and TAKEN to 0, regardless of CLK.
REQ-028 The first rising edge after RST_N deasserts SHALL perform normal RUN behaviour, so PC becomes 8'h01 absent events.
REQ-029 Reset during STALL or REDIR SHALL abandon the pending stall or redirect with no residual pulse.

Configuration
REQ-030 When BRANCH_STATS_EN is defined, the block SHALL add the outputs TAKEN_CNT (8 bits, counts redirects) and STALL_CNT (8 bits, counts cycles with FREEZE=1).
REQ-031 When BRANCH_STATS_EN is defined, both counters SHALL saturate at 8'hFF and clear on reset.
REQ-032 When BRANCH_STATS_EN is undefined, the counter ports and logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-033 Release reset and apply no events for 257 cycles -> PC=8'h01 after edge 1, reaches 8'hFF, and wraps to 8'h00.
REQ-034 At PC=8'h10, hold HOLD=1 for 3 cycles -> PC stays 8'h10, FREEZE=BUBBLE=1 for 3 cycles; then PC=8'h11 with FREEZE=0.
REQ-035 Apply branch_update=1, T4=7'b1010000, CY=1, TGT=8'h40 -> next cycle PC=8'h40, FLUSH=TAKEN=1; following cycle PC=8'h41, FLUSH=0.
REQ-036 Apply branch_update=1, T4=7'b1000001, WZ=0 -> not taken: PC increments, FLUSH=TAKEN=0.
REQ-037 Apply a taken BR_W together with HOLD=1 -> PC=TGT, FLUSH=1, BUBBLE=0; HOLD in the REDIR cycle is ignored.
REQ-038 Pulse RST_N low mid-REDIR -> PC=8'h00 and FLUSH=0 immediately; with BRANCH_STATS_EN defined, TAKEN_CNT=0.
